mux_pkt_arbiter: RTL and testbench

//  Packet-level round-robin arbiter for the 2-input router output mux.
//  - Watches valid/type on both mux inputs, grants one input per packet (HEAD..TAIL).
//  - Drives the mux one-hot sel; issues per-input ready under downstream backpressure.
//  - Sits beside the mux in each router output port; the data path stays in the mux.

---
 rtl/mux_pkt_arbiter_pkg.sv | 19 +
 rtl/mux_pkt_arbiter_rr_pick2.sv | 18 +
 rtl/mux_pkt_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_pkt_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkt_arbiter_pkg.sv
// Shared definitions for the router output-mux packet arbiter:
// flit type codes, type field width and FSM state encodings.
package mux_pkt_arbiter_pkg;

    localparam int TYPEW = 2;

    typedef enum logic [TYPEW-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux_pkt_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. With both requests active the
// pointer chooses the winner; otherwise the lone requester (if any) wins.
// Kept generic so wider muxes can reuse the same interface later.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Resolve the grant from requests and the round-robin pointer.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter for the 2-input router output mux.
// Grants one input per packet (HEAD..TAIL), drives the registered one-hot
// mux select and gives the owner a ready that follows downstream oready.
// Optional per-input completed-packet counters are built when the macro
// MUX_ARB_STATS_EN is defined; without it there are no counter ports.
module mux_pkt_arbiter
    import mux_pkt_arbiter_pkg::*;
#(
    parameter int SELW = 5
`ifdef MUX_ARB_STATS_EN
   ,parameter int CNTW = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    output logic             iready_0,
    output logic             iready_1,
    input  logic             oready,
    output logic [SELW-1:0]  sel,
    output logic             busy,
    output logic             proto_err
`ifdef MUX_ARB_STATS_EN
   ,output logic [CNTW-1:0]  pkt_cnt_0
   ,output logic [CNTW-1:0]  pkt_cnt_1
`endif
);

    state_e           state_q, state_d;
    logic             owner_q;
    logic             rr_ptr_q;
    logic [SELW-1:0]  sel_q;
    logic             perr_q, perr_d;
    logic [1:0]       cand;
    logic [1:0]       gnt;
    logic             own_valid, oth_valid;
    logic [TYPEW-1:0] own_type, oth_type;
    logic             grant;
    logic             xfer;
    logic             tail_xfer;

    // Decode HEAD candidates and steer owner / non-owner input fields.
    always_comb begin
        cand[0]   = ivalid_0 && (itype_0 == TYPE_HEAD);
        cand[1]   = ivalid_1 && (itype_1 == TYPE_HEAD);
        own_valid = owner_q ? ivalid_1 : ivalid_0;
        own_type  = owner_q ? itype_1  : itype_0;
        oth_valid = owner_q ? ivalid_0 : ivalid_1;
        oth_type  = owner_q ? itype_0  : itype_1;
        grant     = (state_q == IDLE) && (|cand);
        xfer      = (state_q == BUSY) && own_valid && oready;
        tail_xfer = xfer && (own_type == TYPE_TAIL);
    end

    rr_pick2 u_pick (
        .req (cand),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant a HEAD in IDLE, release on the owner's TAIL.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (|cand)    state_d = BUSY;
            BUSY:    if (tail_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the owner sees ready, and only while downstream is ready.
    always_comb begin
        iready_0 = 1'b0;
        iready_1 = 1'b0;
        perr_d   = 1'b0;
        if (state_q == BUSY) begin
            iready_0 = !owner_q && oready;
            iready_1 =  owner_q && oready;
            perr_d   = oth_valid && ((oth_type == TYPE_DATA) || (oth_type == TYPE_TAIL));
        end else begin
            perr_d   = (ivalid_0 && (itype_0 != TYPE_HEAD))
                    || (ivalid_1 && (itype_1 != TYPE_HEAD));
        end
    end

    // Grant bookkeeping: owner, one-hot select, round-robin pointer, error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            sel_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            perr_q <= perr_d;
            if (grant) begin
                owner_q <= gnt[1];
                sel_q   <= SELW'(gnt);
            end else if (tail_xfer) begin
                sel_q    <= '0;
                rr_ptr_q <= ~owner_q;
            end
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q == BUSY);
    assign proto_err = perr_q;

`ifdef MUX_ARB_STATS_EN
    // Saturating completed-packet counters, bumped on the owner's TAIL.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else if (tail_xfer) begin
            if (!owner_q && (pkt_cnt_0 != '1)) pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
            if ( owner_q && (pkt_cnt_1 != '1)) pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Self-checking bench for mux_pkt_arbiter. Per-input drivers present queued
// flits and hold each until accepted; expected output order is pushed to a
// scoreboard when stimulus is queued and popped as the DUT accepts flits.
module tb_mux_pkt_arbiter;
    import mux_pkt_arbiter_pkg::*;

    localparam int SELW = 5;

    logic             clk;
    logic             rst;
    logic             ivalid_0, ivalid_1;
    logic [TYPEW-1:0] itype_0, itype_1;
    logic             iready_0, iready_1;
    logic             oready;
    logic [SELW-1:0]  sel;
    logic             busy;
    logic             proto_err;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]      pkt_cnt_0, pkt_cnt_1;
    logic             s_iready_0, s_iready_1, s_busy, s_proto_err;
    logic [SELW-1:0]  s_sel;
    logic [1:0]       s_cnt_0, s_cnt_1;
`endif

    mux_pkt_arbiter #(
        .SELW (SELW)
`ifdef MUX_ARB_STATS_EN
       ,.CNTW (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ivalid_0  (ivalid_0),
        .itype_0   (itype_0),
        .ivalid_1  (ivalid_1),
        .itype_1   (itype_1),
        .iready_0  (iready_0),
        .iready_1  (iready_1),
        .oready    (oready),
        .sel       (sel),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef MUX_ARB_STATS_EN
       ,.pkt_cnt_0 (pkt_cnt_0)
       ,.pkt_cnt_1 (pkt_cnt_1)
`endif
    );

`ifdef MUX_ARB_STATS_EN
    // Narrow-counter copy fed the same stimulus, to observe saturation.
    mux_pkt_arbiter #(.SELW (SELW), .CNTW (2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .ivalid_0  (ivalid_0),
        .itype_0   (itype_0),
        .ivalid_1  (ivalid_1),
        .itype_1   (itype_1),
        .iready_0  (s_iready_0),
        .iready_1  (s_iready_1),
        .oready    (oready),
        .sel       (s_sel),
        .busy      (s_busy),
        .proto_err (s_proto_err),
        .pkt_cnt_0 (s_cnt_0),
        .pkt_cnt_1 (s_cnt_1)
    );
`endif

    typedef struct {
        flit_type_e t;
        bit         once;
    } drv_t;

    typedef struct {
        int         src;
        flit_type_e t;
    } exp_t;

    drv_t drv0_q[$];
    drv_t drv1_q[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int perr_cnt = 0;
    int rdy_cnt1 = 0;
    int xfer_cnt[2];
    int head_cyc[2];
    int tail_cyc[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input int src, input int ndata, input bit with_tail);
        int   n;
        drv_t d;
        exp_t e;
        n = ndata + 1 + (with_tail ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            if (i == 0)                  d.t = TYPE_HEAD;
            else if (with_tail && i == n - 1) d.t = TYPE_TAIL;
            else                         d.t = TYPE_DATA;
            d.once = 1'b0;
            e.src  = src;
            e.t    = d.t;
            if (src == 0) drv0_q.push_back(d);
            else          drv1_q.push_back(d);
            exp_q.push_back(e);
        end
    endtask

    // One-cycle flit that is expected to be refused (no scoreboard entry).
    task automatic inject(input int src, input flit_type_e t);
        drv_t d;
        d.t    = t;
        d.once = 1'b1;
        if (src == 0) drv0_q.push_back(d);
        else          drv1_q.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(drv0_q.size() == 0 && drv1_q.size() == 0 && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            #4;
            n++;
        end
        check("drain", {31'd0, (drv0_q.size() == 0 && drv1_q.size() == 0 && exp_q.size() == 0)}, 32'd1);
    endtask

    task automatic record_xfer(input int src, input logic [TYPEW-1:0] t);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_src", src, e.src);
            check("sb_type", {30'd0, t}, {30'd0, e.t});
        end
        check("sel_owner", {27'd0, sel}, (src == 0) ? 32'd1 : 32'd2);
        xfer_cnt[src]++;
        if (t == TYPE_HEAD) head_cyc[src] = cyc;
        if (t == TYPE_TAIL) tail_cyc[src] = cyc;
    endtask

    // Input 0 driver: present the queue head, pop once it is accepted.
    initial begin
        ivalid_0 = 1'b0;
        itype_0  = TYPE_NONE;
        forever begin
            @(negedge clk);
            #1;
            if (drv0_q.size() > 0) begin
                ivalid_0 = 1'b1;
                itype_0  = drv0_q[0].t;
            end else begin
                ivalid_0 = 1'b0;
                itype_0  = TYPE_NONE;
            end
            #1;
            if (drv0_q.size() > 0 && (iready_0 || drv0_q[0].once)) void'(drv0_q.pop_front());
        end
    end

    // Input 1 driver.
    initial begin
        ivalid_1 = 1'b0;
        itype_1  = TYPE_NONE;
        forever begin
            @(negedge clk);
            #1;
            if (drv1_q.size() > 0) begin
                ivalid_1 = 1'b1;
                itype_1  = drv1_q[0].t;
            end else begin
                ivalid_1 = 1'b0;
                itype_1  = TYPE_NONE;
            end
            #1;
            if (drv1_q.size() > 0 && (iready_1 || drv1_q[0].once)) void'(drv1_q.pop_front());
        end
    end

    // Monitor: every accepted flit is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (ivalid_0 && iready_0) record_xfer(0, itype_0);
            if (ivalid_1 && iready_1) record_xfer(1, itype_1);
            if (proto_err) perr_cnt++;
            if (iready_1) rdy_cnt1++;
        end
    end

    initial begin
        int p;
        xfer_cnt = '{0, 0};
        head_cyc = '{0, 0};
        tail_cyc = '{0, 0};
        rst    = 1'b1;
        oready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #4;
        check("rst_sel", {27'd0, sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_iready_0", {31'd0, iready_0}, 32'd0);
        check("rst_iready_1", {31'd0, iready_1}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
`ifdef MUX_ARB_STATS_EN
        check("rst_pkt_cnt_0", {16'd0, pkt_cnt_0}, 32'd0);
        check("rst_pkt_cnt_1", {16'd0, pkt_cnt_1}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single packet on input 1: HEAD, 20 DATA, TAIL.
        @(negedge clk);
        rdy_cnt1 = 0;
        send_pkt(1, 20, 1'b1);
        @(negedge clk);
        #4;
        check("t1_sel", {27'd0, sel}, 32'd2);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_iready_1", {31'd0, iready_1}, 32'd1);
        wait_drain(100);
        @(negedge clk);
        #4;
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_sel", {27'd0, sel}, 32'd0);
        check("t1_ready_cycles", rdy_cnt1, 32'd22);

        // Contention: in0 wins first, one bubble, then in1; waiting HEAD is legal.
        @(negedge clk);
        p = perr_cnt;
        send_pkt(0, 2, 1'b1);
        send_pkt(1, 1, 1'b1);
        @(negedge clk);
        #4;
        check("t2_sel_first", {27'd0, sel}, 32'd1);
        wait_drain(100);
        @(negedge clk);
        #4;
        check("t2_bubble", head_cyc[1] - tail_cyc[0], 32'd2);
        check("t2_no_perr", perr_cnt, p);

        // Pointer returned to in0 after in1 finished.
        @(negedge clk);
        send_pkt(0, 0, 1'b1);
        send_pkt(1, 0, 1'b1);
        @(negedge clk);
        #4;
        check("t2_rr_back_0", {27'd0, sel}, 32'd1);
        wait_drain(100);
        @(negedge clk);

        // Backpressure mid-packet on input 0.
        xfer_cnt[0] = 0;
        send_pkt(0, 20, 1'b1);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #4;
            if (xfer_cnt[0] >= 5) break;
        end
        @(negedge clk);
        oready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #4;
            check("t3_hold_iready_0", {31'd0, iready_0}, 32'd0);
            check("t3_hold_sel", {27'd0, sel}, 32'd1);
            check("t3_hold_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        oready = 1'b1;
        wait_drain(100);
        @(negedge clk);
        #4;
        check("t3_flit_count", xfer_cnt[0], 32'd22);

        // Protocol error: DATA on in0 while IDLE.
        @(negedge clk);
        p = perr_cnt;
        inject(0, TYPE_DATA);
        #4;
        check("t4_iready_0", {31'd0, iready_0}, 32'd0);
        @(negedge clk);
        #4;
        check("t4_perr", {31'd0, proto_err}, 32'd1);
        check("t4_no_grant_busy", {31'd0, busy}, 32'd0);
        check("t4_no_grant_sel", {27'd0, sel}, 32'd0);
        @(negedge clk);
        #4;
        check("t4_perr_drop", {31'd0, proto_err}, 32'd0);
        check("t4_perr_pulses", perr_cnt, p + 1);

        // Protocol error: TAIL on the non-owner while BUSY.
        @(negedge clk);
        send_pkt(0, 3, 1'b1);
        @(negedge clk);
        p = perr_cnt;
        inject(1, TYPE_TAIL);
        @(negedge clk);
        #4;
        check("t4b_perr", {31'd0, proto_err}, 32'd1);
        wait_drain(100);
        @(negedge clk);
        #4;
        check("t4b_perr_pulses", perr_cnt, p + 1);

        // Reset after HEAD + 3 DATA of an in1 packet (pointer currently at in1).
        @(negedge clk);
        send_pkt(1, 3, 1'b0);
        wait_drain(100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("t5_sel", {27'd0, sel}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_iready_1", {31'd0, iready_1}, 32'd0);
        check("t5_proto_err", {31'd0, proto_err}, 32'd0);
        @(negedge clk);
        send_pkt(0, 0, 1'b1);
        send_pkt(1, 0, 1'b1);
        @(negedge clk);
        #4;
        check("t5_rr_reset", {27'd0, sel}, 32'd1);
        wait_drain(100);
        @(negedge clk);
        #4;

`ifdef MUX_ARB_STATS_EN
        // One packet per input so far since reset; add 9 on in1 and 3 on in0.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            send_pkt((i < 9) ? 1 : 0, 1, 1'b1);
            wait_drain(100);
            @(negedge clk);
            #4;
        end
        check("t6_pkt_cnt_1", {16'd0, pkt_cnt_1}, 32'd10);
        check("t6_pkt_cnt_0", {16'd0, pkt_cnt_0}, 32'd4);
        check("t6_sat_cnt_1", {30'd0, s_cnt_1}, 32'd3);
        check("t6_sat_cnt_0", {30'd0, s_cnt_0}, 32'd3);
`endif

        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
